wb_rr_arbiter: RTL and testbench
================================

Name: wb_rr_arbiter

Overview:
- N:1 Wishbone round-robin arbiter that shares one downstream Wishbone bus (e.g. the SPI flash/SRAM controller) between NUM_PORTS upstream masters.
- Adds per-tenure beat limiting, so one master cannot starve the others.
- Adds a bus watchdog that aborts a stalled slave with err.
- Sits between the request sources (CPU, DMA, accelerator) and the single memory-side slave.

Parameters:
NUM_PORTS, 4, number of upstream masters (2..8)
ADDR_WIDTH, 24, address width
DATA_WIDTH, 8, data width
SEL_WIDTH, DATA_WIDTH/8, byte-select width
MAX_BEATS, 16, acks allowed per tenure before a yield is forced while another port is waiting (1..255)
TIMEOUT, 255, cycles a forwarded strobe may wait for ack/err/rty before the watchdog fires (1..65535)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
wbs_cyc_i  in  NUM_PORTS  per-port cycle
wbs_stb_i  in  NUM_PORTS  per-port strobe
wbs_adr_i  in  NUM_PORTS*ADDR_WIDTH  per-port address, port i at slice i
wbs_we_i  in  NUM_PORTS  per-port write enable
wbs_sel_i  in  NUM_PORTS*SEL_WIDTH  per-port byte select
wbs_dat_i  in  NUM_PORTS*DATA_WIDTH  per-port write data
wbs_cti_i  in  NUM_PORTS*3  per-port cycle type
wbs_bte_i  in  NUM_PORTS*2  per-port burst type
wbs_ack_o  out  NUM_PORTS  per-port ack
wbs_err_o  out  NUM_PORTS  per-port err
wbs_rty_o  out  NUM_PORTS  per-port retry
wbs_dat_o  out  DATA_WIDTH  read data, broadcast to all ports
wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1  downstream cycle, strobe, write enable
wbm_adr_o  out  ADDR_WIDTH  downstream address
wbm_sel_o  out  SEL_WIDTH  downstream byte select
wbm_dat_o  out  DATA_WIDTH  downstream write data
wbm_cti_o  out  3  downstream cycle type
wbm_bte_o  out  2  downstream burst type
wbm_ack_i, wbm_err_i, wbm_rty_i  in  1  downstream terminations
wbm_dat_i  in  DATA_WIDTH  downstream read data
gnt_o  out  NUM_PORTS  one-hot current owner; all zero in IDLE
timeout_o  out  1  one-cycle pulse when the watchdog fires

Behaviour:
- Reset (rst_ni low, asynchronous):
  - state=IDLE, gnt=0, pointer=0, beat count=0, watchdog=0.
  - All outputs 0 except wbs_dat_o, which equals wbm_dat_i.
- FSM states: IDLE, BUSY, YIELD, ABORT.
- IDLE:
  - If any wbs_cyc_i is high, grant the first requesting port searching upward from pointer, wrapping at NUM_PORTS.
  - gnt and BUSY are registered; wbm_cyc_o rises the cycle after the request is seen (1-cycle grant latency).
- BUSY:
  - wbm_cyc_o=1.
  - stb/adr/we/sel/dat/cti/bte are muxed from the granted port.
  - wbs_ack/err/rty_o of the granted port equal the wbm terminations; all other ports get 0.
  - Granted wbs_cyc_i low: next state IDLE; pointer = granted index+1 (wrap); beat count cleared.
- Beat limit:
  - Beat count increments on each wbm_ack_i and saturates at MAX_BEATS.
  - When count==MAX_BEATS, another port's cyc is high, and the granted master asserts stb:
    - that strobe is not forwarded (wbm_stb_o=0);
    - wbs_rty_o of the granted port pulses high for that cycle;
    - next state YIELD.
  - If no other port is requesting, the limit is ignored.
- YIELD and ABORT:
  - wbm_cyc_o=0 and wbm_stb_o=0.
  - Granted-port terminations are held at 0.
  - On granted wbs_cyc_i low: next state IDLE and pointer advances, as in BUSY.
- Watchdog:
  - In BUSY, counts cycles with wbm_stb_o high and no termination; cleared on any termination or when stb is low.
  - On reaching TIMEOUT: wbs_err_o of the granted port pulses for 1 cycle, timeout_o pulses, next state ABORT.
  - A late wbm_ack_i arriving in ABORT is dropped.
- Simultaneous events:
  - A termination in the same cycle the watchdog reaches TIMEOUT wins; no err, counter cleared.
  - Granted cyc dropping in the same cycle as a beat-limit strobe: the cyc drop wins and no rty is issued.
- Reset mid-operation: all state returns to reset values immediately; wbm_cyc_o drops asynchronously.
- Counter widths: beat count is clog2(MAX_BEATS+1) bits; watchdog is clog2(TIMEOUT+1) bits.

Decomposition:
- Shared package wb_pkg holds:
  - the arbiter state enum;
  - CTI constants (CLASSIC=3'b000, INCR=3'b010, EOB=3'b111);
  - BTE constants.
- Sub-module rr_pick: combinational round-robin priority picker.
  - Inputs: req[NUM_PORTS], pointer.
  - Outputs: one-hot grant and valid.
  - Reusable by other arbiters.

Test Plan:
- Port 2 alone raises cyc and stb, reads address 0x000010; slave acks after 3 cycles with 0xA5 -> wbm_cyc_o rises 1 cycle after the request; wbs_ack_o=4'b0100 for one cycle; wbs_dat_o=0xA5; gnt_o=4'b0100.
- Ports 0, 1 and 3 all request continuously, each doing single transfers and dropping cyc after each ack -> grant order is 0,1,3,0,1,3; at least 1 IDLE cycle between tenures.
- MAX_BEATS=4, port 0 bursts 8 beats while port 1 requests -> after the 4th ack, port 0's 5th strobe gets rty and is not forwarded; after port 0 drops cyc, port 1 is granted.
- MAX_BEATS=4, port 0 bursts 8 beats with no other requester -> all 8 acks are forwarded and no rty is issued.
- TIMEOUT=10, slave never acks -> wbs_err_o of the granted port and timeout_o pulse exactly 10 cycles after stb; wbm_cyc_o is low in ABORT; an ack injected in ABORT is not forwarded.
- rst_ni pulsed low mid-burst -> all outputs 0 asynchronously; after release, the next request is granted starting from port 0.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared Wishbone definitions: arbiter FSM states and cycle/burst type encodings.
package wb_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StBusy  = 2'd1,
        StYield = 2'd2,
        StAbort = 2'd3
    } arb_state_e;

    // Cycle type identifiers
    localparam logic [2:0] CtiClassic = 3'b000;
    localparam logic [2:0] CtiIncr    = 3'b010;
    localparam logic [2:0] CtiEob     = 3'b111;

    // Burst type extensions
    localparam logic [1:0] BteLinear = 2'b00;
    localparam logic [1:0] BteWrap4  = 2'b01;
    localparam logic [1:0] BteWrap8  = 2'b10;
    localparam logic [1:0] BteWrap16 = 2'b11;

endpackage

// File: rtl/wb_rr_arbiter_if.sv
// Wishbone bundle for one or more masters; per-port fields are packed at slice i.
// Read data is a single shared bus.
interface wb_rr_arbiter_if #(
    parameter int unsigned NUM_PORTS  = 1,
    parameter int unsigned ADDR_WIDTH = 24,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned SEL_WIDTH  = DATA_WIDTH / 8
);
    logic [NUM_PORTS-1:0]            cyc;
    logic [NUM_PORTS-1:0]            stb;
    logic [NUM_PORTS-1:0]            we;
    logic [NUM_PORTS*ADDR_WIDTH-1:0] adr;
    logic [NUM_PORTS*SEL_WIDTH-1:0]  sel;
    logic [NUM_PORTS*DATA_WIDTH-1:0] dat_w;
    logic [NUM_PORTS*3-1:0]          cti;
    logic [NUM_PORTS*2-1:0]          bte;
    logic [NUM_PORTS-1:0]            ack;
    logic [NUM_PORTS-1:0]            err;
    logic [NUM_PORTS-1:0]            rty;
    logic [DATA_WIDTH-1:0]           dat_r;

    modport master (
        output cyc, stb, we, adr, sel, dat_w, cti, bte,
        input  ack, err, rty, dat_r
    );

    modport slave (
        input  cyc, stb, we, adr, sel, dat_w, cti, bte,
        output ack, err, rty, dat_r
    );
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr_i, wrapping.
module rr_pick #(
    parameter int unsigned NUM_PORTS = 4,
    localparam int unsigned PtrWidth = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic [PtrWidth-1:0]  ptr_i,
    output logic [NUM_PORTS-1:0] gnt_o,
    output logic                 valid_o
);
    // Scan every offset from the pointer; the first hit wins.
    always_comb begin
        gnt_o   = '0;
        valid_o = 1'b0;
        for (int unsigned off = 0; off < NUM_PORTS; off++) begin
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                if (!valid_o && req_i[p] &&
                    (p == (int'(ptr_i) + off) % NUM_PORTS)) begin
                    gnt_o[p] = 1'b1;
                    valid_o  = 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/wb_rr_arbiter.sv
// N:1 Wishbone round-robin arbiter with per-tenure beat limiting and a stall watchdog.
module wb_rr_arbiter
    import wb_pkg::*;
#(
    parameter int unsigned NUM_PORTS  = 4,
    parameter int unsigned ADDR_WIDTH = 24,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned SEL_WIDTH  = DATA_WIDTH / 8,
    parameter int unsigned MAX_BEATS  = 16,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    wb_rr_arbiter_if.slave       wbs,
    wb_rr_arbiter_if.master      wbm,
    output logic [NUM_PORTS-1:0] gnt_o,
    output logic                 timeout_o
);
    localparam int unsigned PtrWidth  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int unsigned BeatWidth = $clog2(MAX_BEATS + 1);
    localparam int unsigned WdogWidth = $clog2(TIMEOUT + 1);
    localparam logic [BeatWidth-1:0] BeatMax  = BeatWidth'(MAX_BEATS);
    localparam logic [WdogWidth-1:0] WdogMax  = WdogWidth'(TIMEOUT);
    localparam logic [PtrWidth-1:0]  LastPort = PtrWidth'(NUM_PORTS - 1);

    arb_state_e             state_q, state_d;
    logic [NUM_PORTS-1:0]   gnt_q, gnt_d;
    logic [PtrWidth-1:0]    ptr_q, ptr_d;
    logic [BeatWidth-1:0]   beat_q, beat_d;
    logic [WdogWidth-1:0]   wdog_q, wdog_d;

    logic [NUM_PORTS-1:0]   pick_gnt;
    logic                   pick_valid;
    logic [PtrWidth-1:0]    gnt_idx;
    logic                   g_cyc, g_stb, g_we;
    logic [ADDR_WIDTH-1:0]  g_adr;
    logic [SEL_WIDTH-1:0]   g_sel;
    logic [DATA_WIDTH-1:0]  g_dat;
    logic [2:0]             g_cti;
    logic [1:0]             g_bte;
    logic                   busy, others_req, term, yield_rty, stb_fwd, fire, release_bus;

    rr_pick #(
        .NUM_PORTS(NUM_PORTS)
    ) u_pick (
        .req_i  (wbs.cyc),
        .ptr_i  (ptr_q),
        .gnt_o  (pick_gnt),
        .valid_o(pick_valid)
    );

    // Select the granted port's request fields using the registered one-hot grant.
    always_comb begin
        gnt_idx = '0;
        g_cyc   = 1'b0;
        g_stb   = 1'b0;
        g_we    = 1'b0;
        g_adr   = '0;
        g_sel   = '0;
        g_dat   = '0;
        g_cti   = '0;
        g_bte   = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (gnt_q[i]) begin
                gnt_idx = PtrWidth'(i);
                g_cyc   = wbs.cyc[i];
                g_stb   = wbs.stb[i];
                g_we    = wbs.we[i];
                g_adr   = wbs.adr[i*ADDR_WIDTH +: ADDR_WIDTH];
                g_sel   = wbs.sel[i*SEL_WIDTH +: SEL_WIDTH];
                g_dat   = wbs.dat_w[i*DATA_WIDTH +: DATA_WIDTH];
                g_cti   = wbs.cti[i*3 +: 3];
                g_bte   = wbs.bte[i*2 +: 2];
            end
        end
    end

    assign busy        = (state_q == StBusy);
    assign others_req  = |(wbs.cyc & ~gnt_q);
    assign term        = wbm.ack[0] | wbm.err[0] | wbm.rty[0];
    // A dropping cyc suppresses the yield retry, so it is gated by g_cyc.
    assign yield_rty   = busy & g_cyc & g_stb & others_req & (beat_q == BeatMax);
    assign stb_fwd     = busy & g_cyc & g_stb & ~yield_rty;
    // A termination arriving in the expiry cycle wins over the watchdog.
    assign fire        = stb_fwd & ~term & (wdog_q == WdogMax);
    assign release_bus = (state_q != StIdle) & ~g_cyc;

    // Next-state logic: grant, beat limit, watchdog and end-of-tenure handling.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        beat_d  = beat_q;
        wdog_d  = wdog_q;
        if (release_bus) begin
            state_d = StIdle;
            gnt_d   = '0;
            ptr_d   = (gnt_idx == LastPort) ? '0 : gnt_idx + 1'b1;
            beat_d  = '0;
            wdog_d  = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (pick_valid) begin
                        state_d = StBusy;
                        gnt_d   = pick_gnt;
                        beat_d  = '0;
                        wdog_d  = '0;
                    end
                end
                StBusy: begin
                    if (yield_rty) begin
                        state_d = StYield;
                        wdog_d  = '0;
                    end else if (fire) begin
                        state_d = StAbort;
                        wdog_d  = '0;
                    end else begin
                        if (wbm.ack[0] && (beat_q != BeatMax)) beat_d = beat_q + 1'b1;
                        wdog_d = (stb_fwd && !term) ? wdog_q + 1'b1 : '0;
                    end
                end
                StYield, StAbort: ;
                default: state_d = StIdle;
            endcase
        end
    end

    // Arbiter state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            gnt_q   <= '0;
            ptr_q   <= '0;
            beat_q  <= '0;
            wdog_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            beat_q  <= beat_d;
            wdog_q  <= wdog_d;
        end
    end

    assign gnt_o     = gnt_q;
    assign timeout_o = fire;

    assign wbm.cyc   = busy;
    assign wbm.stb   = stb_fwd;
    assign wbm.we    = busy & g_we;
    assign wbm.adr   = busy ? g_adr : '0;
    assign wbm.sel   = busy ? g_sel : '0;
    assign wbm.dat_w = busy ? g_dat : '0;
    assign wbm.cti   = busy ? g_cti : '0;
    assign wbm.bte   = busy ? g_bte : '0;

    assign wbs.ack   = gnt_q & {NUM_PORTS{busy & wbm.ack[0]}};
    assign wbs.err   = gnt_q & {NUM_PORTS{busy & (wbm.err[0] | fire)}};
    assign wbs.rty   = gnt_q & {NUM_PORTS{busy & (wbm.rty[0] | yield_rty)}};
    assign wbs.dat_r = wbm.dat_r;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Self-checking bench for wb_rr_arbiter (4 ports, MAX_BEATS=4, TIMEOUT=10).
module tb_wb_rr_arbiter;
    import wb_pkg::*;

    localparam int unsigned NP = 4;
    localparam int unsigned AW = 24;
    localparam int unsigned DW = 8;
    localparam int unsigned MB = 4;
    localparam int unsigned TO = 10;

    logic          clk = 1'b0;
    logic          rst_ni = 1'b0;
    logic [NP-1:0] gnt;
    logic          timeout;

    always #5 clk = ~clk;

    wb_rr_arbiter_if #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) up_if ();
    wb_rr_arbiter_if #(.NUM_PORTS(1),  .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dn_if ();

    wb_rr_arbiter #(
        .NUM_PORTS (NP),
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .MAX_BEATS (MB),
        .TIMEOUT   (TO)
    ) dut (
        .clk_i    (clk),
        .rst_ni   (rst_ni),
        .wbs      (up_if),
        .wbm      (dn_if),
        .gnt_o    (gnt),
        .timeout_o(timeout)
    );

    int            n_tests = 0;
    int            n_fail  = 0;
    int unsigned   model_ptr = 0;
    logic [AW-1:0] port_adr [NP];
    logic [NP-1:0] port_we = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference rule: first requester at or after the pointer, wrapping.
    function automatic int unsigned rr_model(input logic [NP-1:0] req, input int unsigned ptr);
        for (int unsigned k = 0; k < NP; k++) begin
            if (((req >> ((ptr + k) % NP)) & 4'b0001) != 4'b0000) return (ptr + k) % NP;
        end
        return NP;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic set_req(input logic [NP-1:0] mask);
        up_if.cyc = mask;
        up_if.stb = mask;
        up_if.we  = port_we;
        for (int i = 0; i < NP; i++) up_if.adr[i*AW +: AW] = port_adr[i];
    endtask

    task automatic rand_ports();
        for (int i = 0; i < NP; i++) port_adr[i] = AW'($urandom);
        port_we = NP'($urandom);
    endtask

    // Single-transfer tenure; starts and ends at a falling edge with the arbiter idle.
    task automatic run_tenure(input string tag, input logic [NP-1:0] mask,
                              input int unsigned wait_cyc, input logic [DW-1:0] rdata);
        int unsigned   exp;
        logic [NP-1:0] exp_oh;
        logic [NP-1:0] rest;
        exp    = rr_model(mask, model_ptr);
        exp_oh = NP'(1) << exp;
        set_req(mask);
        #1;
        chk({tag, "_idle_cyc"}, 32'(dn_if.cyc), 32'd0);
        tick();
        settle();
        chk({tag, "_gnt"}, 32'(gnt), 32'(exp_oh));
        chk({tag, "_cyc"}, 32'(dn_if.cyc), 32'd1);
        chk({tag, "_adr"}, 32'(dn_if.adr), 32'(port_adr[exp]));
        chk({tag, "_we"},  32'(dn_if.we), 32'(|(port_we & exp_oh)));
        repeat (wait_cyc) begin
            tick();
            settle();
        end
        tick();
        dn_if.ack   = 1'b1;
        dn_if.dat_r = rdata;
        settle();
        chk({tag, "_ack"}, 32'(up_if.ack), 32'(exp_oh));
        chk({tag, "_dat"}, 32'(up_if.dat_r), 32'(rdata));
        tick();
        dn_if.ack = 1'b0;
        rest = mask & ~exp_oh;
        set_req(rest);
        settle();
        tick();
        settle();
        chk({tag, "_gap_gnt"}, 32'(gnt), 32'd0);
        chk({tag, "_gap_cyc"}, 32'(dn_if.cyc), 32'd0);
        model_ptr = (exp + 1) % NP;
    endtask

    initial begin
        logic [NP-1:0] mask;
        logic [DW-1:0] d;
        int            n_acks;
        logic          flag;

        up_if.cyc   = '0;
        up_if.stb   = '0;
        up_if.we    = '0;
        up_if.adr   = '0;
        up_if.sel   = '1;
        up_if.dat_w = '0;
        up_if.cti   = '0;
        up_if.bte   = '0;
        dn_if.ack   = 1'b1;
        dn_if.err   = 1'b0;
        dn_if.rty   = 1'b0;
        dn_if.dat_r = 8'h3C;
        for (int i = 0; i < NP; i++) port_adr[i] = '0;

        // Reset: requests and a stray ack are ignored; read data still passes through.
        set_req(4'b1111);
        #12;
        chk("rst_cyc", 32'(dn_if.cyc), 32'd0);
        chk("rst_stb", 32'(dn_if.stb), 32'd0);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_ack", 32'(up_if.ack), 32'd0);
        chk("rst_tmo", 32'(timeout), 32'd0);
        chk("rst_dat", 32'(up_if.dat_r), 32'h3C);
        repeat (2) tick();
        chk("rst_hold_cyc", 32'(dn_if.cyc), 32'd0);
        dn_if.ack = 1'b0;
        set_req('0);
        settle();
        rst_ni = 1'b1;

        // Lone port 2 read of 0x000010, acked 3 cycles after grant with 0xA5.
        rand_ports();
        port_adr[2] = 24'h000010;
        port_we     = '0;
        run_tenure("single_p2", 4'b0100, 2, 8'hA5);

        // Ports 0, 1, 3 requesting continuously.
        for (int r = 0; r < 6; r++) begin
            rand_ports();
            run_tenure("rr_013", 4'b1011, $urandom_range(0, 3), DW'($urandom));
        end

        // Random request sets.
        for (int r = 0; r < 6; r++) begin
            rand_ports();
            mask = NP'($urandom_range(1, 15));
            run_tenure("rr_rand", mask, $urandom_range(0, 2), DW'($urandom));
        end

        // Beat limit: port 0 bursts while port 1 waits.
        rand_ports();
        up_if.cti[2:0] = CtiIncr;
        set_req(4'b0001);
        model_ptr = rr_model(4'b0001, model_ptr);
        tick();
        settle();
        chk("lim_gnt0", 32'(gnt), 32'h1);
        chk("lim_cti", 32'(dn_if.cti), 32'(CtiIncr));
        set_req(4'b0011);
        for (int b = 0; b < MB; b++) begin
            tick();
            d = DW'($urandom);
            dn_if.ack   = 1'b1;
            dn_if.dat_r = d;
            settle();
            chk("lim_ack", 32'(up_if.ack), 32'h1);
            chk("lim_dat", 32'(up_if.dat_r), 32'(d));
        end
        tick();
        dn_if.ack = 1'b0;
        settle();
        chk("lim_stb_blocked", 32'(dn_if.stb), 32'd0);
        chk("lim_rty", 32'(up_if.rty), 32'h1);
        tick();
        settle();
        chk("lim_yield_cyc", 32'(dn_if.cyc), 32'd0);
        chk("lim_yield_rty", 32'(up_if.rty), 32'd0);
        tick();
        up_if.cti = '0;
        set_req(4'b0010);
        settle();
        tick();
        settle();
        chk("lim_idle_gnt", 32'(gnt), 32'd0);
        model_ptr = 1;
        run_tenure("lim_next", 4'b0011, 0, DW'($urandom));

        // Burst beyond the limit with no competitor: never throttled.
        rand_ports();
        set_req(4'b0001);
        model_ptr = 1;
        tick();
        settle();
        chk("nolim_gnt", 32'(gnt), 32'h1);
        n_acks = 0;
        flag   = 1'b0;
        for (int b = 0; b < 2 * MB; b++) begin
            tick();
            dn_if.ack = 1'b1;
            settle();
            if (up_if.ack == 4'b0001) n_acks++;
            flag = flag | (|up_if.rty) | ~dn_if.stb;
        end
        chk("nolim_acks", 32'(n_acks), 32'(2 * MB));
        chk("nolim_rty_or_block", 32'(flag), 32'd0);
        tick();
        dn_if.ack = 1'b0;
        set_req('0);
        settle();
        tick();
        settle();
        chk("nolim_idle", 32'(gnt), 32'd0);

        // Watchdog: port 2 strobes, slave silent.
        set_req(4'b0100);
        tick();
        settle();
        chk("wd_gnt", 32'(gnt), 32'h4);
        flag = 1'b0;
        for (int c = 0; c < TO; c++) begin
            if (c > 0) begin
                tick();
                settle();
            end
            flag = flag | (|up_if.err) | timeout;
        end
        chk("wd_early", 32'(flag), 32'd0);
        tick();
        settle();
        chk("wd_err", 32'(up_if.err), 32'h4);
        chk("wd_tmo", 32'(timeout), 32'd1);
        tick();
        dn_if.ack = 1'b1;
        settle();
        chk("wd_abort_cyc", 32'(dn_if.cyc), 32'd0);
        chk("wd_late_ack", 32'(up_if.ack), 32'd0);
        chk("wd_tmo_once", 32'(timeout), 32'd0);
        tick();
        dn_if.ack = 1'b0;
        set_req('0);
        settle();
        tick();
        settle();
        chk("wd_idle", 32'(gnt), 32'd0);
        model_ptr = 3;

        // Ack in the expiry cycle beats the watchdog.
        set_req(4'b1000);
        tick();
        settle();
        chk("tie_gnt", 32'(gnt), 32'h8);
        repeat (TO - 1) begin
            tick();
            settle();
        end
        tick();
        dn_if.ack = 1'b1;
        settle();
        chk("tie_ack", 32'(up_if.ack), 32'h8);
        chk("tie_err", 32'(up_if.err), 32'd0);
        chk("tie_tmo", 32'(timeout), 32'd0);
        tick();
        dn_if.ack = 1'b0;
        settle();
        chk("tie_still_busy", 32'(dn_if.cyc), 32'd1);
        chk("tie_no_err", 32'(up_if.err), 32'd0);
        tick();
        set_req('0);
        settle();
        tick();
        settle();
        model_ptr = 0;
        rand_ports();
        run_tenure("pre_rst", 4'b0001, 0, DW'($urandom));

        // Reset asserted mid-burst on port 2.
        set_req(4'b0100);
        tick();
        settle();
        chk("mid_gnt", 32'(gnt), 32'h4);
        tick();
        dn_if.ack = 1'b1;
        settle();
        #1;
        rst_ni = 1'b0;
        #1;
        chk("mid_rst_cyc", 32'(dn_if.cyc), 32'd0);
        chk("mid_rst_stb", 32'(dn_if.stb), 32'd0);
        chk("mid_rst_gnt", 32'(gnt), 32'd0);
        chk("mid_rst_ack", 32'(up_if.ack), 32'd0);
        chk("mid_rst_adr", 32'(dn_if.adr), 32'd0);
        dn_if.ack = 1'b0;
        set_req('0);
        tick();
        settle();
        rst_ni    = 1'b1;
        model_ptr = 0;
        rand_ports();
        run_tenure("post_rst", 4'b1111, 1, DW'($urandom));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Absolute time guard.
    initial begin
        #200000;
        $display("FAIL timeout_guard: observed running expected finished");
        $fatal(1, "bench time limit");
    end

endmodule
